// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, PC step, fetch state and IF/ID bundle.
package mips_pkg;

  localparam logic [5:0]  OPC_J   = 6'b000010;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                           input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: redirect > hold > jump target > sequential.
// Jump predecode is enabled by defining INSTR_FETCH_JUMP_PREDECODE_EN.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic        unused_bits;

  assign pc_plus4 = pc + PC_STEP;

`ifdef INSTR_FETCH_JUMP_PREDECODE_EN
  assign unused_bits = ^redirect_pc[1:0];
`else
  assign unused_bits = ^{redirect_pc[1:0], instr};
`endif

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (advance) begin
`ifdef INSTR_FETCH_JUMP_PREDECODE_EN
      if (instr[31:26] == OPC_J) next_pc = j_target(pc_plus4, instr);
      else                       next_pc = pc_plus4;
`else
      next_pc = pc_plus4;
`endif
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID output register, valid/ready to decode.
// Optional `j` predecode via INSTR_FETCH_JUMP_PREDECODE_EN (see fetch_next_pc).
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         valid;
  logic         advance;
  if_id_t       ifid;

  // RUN only captures into an empty or draining register so an unaccepted word is never overwritten
  assign advance = ((state == RUN) && (!valid || out_ready)) ||
                   ((state == HOLD) && out_ready);

  fetch_next_pc u_next_pc (
    .pc             (pc),
    .instr          (imem_instr),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      valid       <= 1'b0;
      ifid        <= '{instr: '0, pc: '0, pc_plus4: PC_STEP};
      fetch_count <= '0;
    end else begin
      pc <= next_pc;
      if (valid && out_ready) fetch_count <= fetch_count + 32'd1;

      if (redirect_valid) begin
        valid <= 1'b0;
      end else if (advance) begin
        valid <= 1'b1;
        ifid  <= '{instr: imem_instr, pc: pc, pc_plus4: pc + PC_STEP};
      end

      case (state)
        BOOT:    state <= RUN;
        default: state <= (valid && !out_ready && !redirect_valid && !advance) ? HOLD : RUN;
      endcase
    end
  end

  assign imem_addr    = pc;
  assign out_valid    = valid;
  assign out_instr    = ifid.instr;
  assign out_pc       = ifid.pc;
  assign out_pc_plus4 = ifid.pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random ready/redirect traffic.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] fetch_count;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: architectural view of the stage
  logic [31:0] m_pc, m_instr, m_opc, m_cnt;
  logic        m_valid, m_boot;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h22000004;
      32'h4:   return 32'h22200006;
      32'h8:   return 32'h02119820;
      32'hC:   return 32'h08000000;
      32'h10:  return 32'h00000000;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  always_comb imem_instr = rom(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_opc = '0; m_cnt = '0;
    m_valid = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_edge(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] w;
    if (m_valid && rdy) m_cnt = m_cnt + 1;
    if (rv) begin
      m_pc    = rpc & 32'hFFFFFFFC;
      m_valid = 1'b0;
    end else if (!m_boot && (!m_valid || rdy)) begin
      w       = rom(m_pc);
      m_instr = w;
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
`ifdef INSTR_FETCH_JUMP_PREDECODE_EN
      if (w[31:26] == 6'b000010) m_pc = {m_pc[31:28], w[25:0], 2'b00};
`endif
    end
    m_boot = 1'b0;
  endtask

  task automatic check_all();
    chk("out_valid",    {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_instr",    out_instr,    m_instr);
    chk("out_pc",       out_pc,       m_opc);
    chk("out_pc_plus4", out_pc_plus4, m_opc + 4);
    chk("imem_addr",    imem_addr,    m_pc);
    chk("fetch_count",  fetch_count,  m_cnt);
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_edge(rdy, rv, rpc);
    @(negedge clk);
    check_all();
  endtask

  task automatic restart_check();
    cyc(1'b1, 1'b0, '0);
    chk("boot_no_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, RST_PC);
    chk("first_instr", out_instr, 32'h22000004);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Straight-line fetch, then run until out_pc = 0xC
    restart_check();
    for (int i = 0; i < 20 && !(m_valid && m_opc == 32'hC); i++) cyc(1'b1, 1'b0, '0);
    chk("reach_c", out_pc, 32'hC);

    // Redirect to 0 the cycle after 0xC is accepted
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h0);
    chk("redir_bubble", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, '0);
    chk("redir_instr", out_instr, 32'h22000004);
    chk("redir_valid", {31'd0, out_valid}, 32'd1);

    // Hold at out_pc = 4 for three cycles
    for (int i = 0; i < 20 && !(m_valid && m_opc == 32'h4); i++) cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk("hold_pc", out_pc, 32'h4);
      chk("hold_addr", imem_addr, 32'h8);
    end
    cyc(1'b1, 1'b0, '0);
    chk("resume_pc", out_pc, 32'h8);

    // Redirect with unaligned target while holding
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h00000013);
    chk("hold_redir_addr", imem_addr, 32'h10);
    chk("hold_redir_drop", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("hold_redir_pc", out_pc, 32'h10);

    // PC wrap
    cyc(1'b1, 1'b1, 32'hFFFFFFFC);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_pc", out_pc, 32'hFFFFFFFC);
    chk("wrap_plus4", out_pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, '0);

    // Asynchronous reset mid-stream, then identical restart
    out_ready = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    restart_check();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0);

    // Random ready/redirect traffic
    for (int i = 0; i < 400; i++) begin
      logic        r, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h00000FFF);
      cyc(r, rv, t);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-issue MIPS core. Owns the program counter, drives the read address of the combinational instruction memory, and captures the returned word into an IF/ID output register. Hands instructions to decode over a valid/ready handshake. Accepts PC redirects from later stages and, optionally, resolves `j` itself.

## Interface
- `RESET_PC`, default 32'h00000000: PC loaded on reset.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_addr`  out  32  instruction memory read address; equals the PC register.
- `imem_instr`  in  32  instruction word; combinational function of `imem_addr`, valid in the same cycle.
- `redirect_valid`  in  1  PC redirect request from branch/jump resolution.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `out_valid`  out  1  IF/ID register holds an instruction.
- `out_ready`  in  1  decode accepts the instruction this cycle.
- `out_instr`  out  32  fetched instruction.
- `out_pc`  out  32  address of `out_instr`.
- `out_pc_plus4`  out  32  `out_pc + 4`, modulo 2^32.
- `fetch_count`  out  32  number of instructions accepted by decode; wraps.

## Operation
- States:
  - `BOOT`: one cycle after reset release. No capture.
  - `RUN`: normal fetch.
  - `HOLD`: `out_valid` is set and `out_ready` is low.
- Transitions:
  - `BOOT`→`RUN` unconditionally.
  - `RUN`→`HOLD` when the register is full and not accepted.
  - `HOLD`→`RUN` on `out_ready` or on redirect.
- Capture rule: in `RUN`, or in `HOLD` with `out_ready`, on each cycle:
  - `out_instr` ← `imem_instr`
  - `out_pc` ← `pc`
  - `out_valid` ← 1
  - `pc` ← next_pc
- While held, `pc` and the output register stay unchanged.
- next_pc defaults to `pc + 4`. Arithmetic is 32-bit unsigned; 32'hFFFFFFFC wraps to 0.
- Priority is redirect > hold > advance.
  - On redirect: `pc` ← `{redirect_pc[31:2],2'b00}` and `out_valid` ← 0 next cycle, even if the held word is being accepted in the same cycle.
  - That accepted word still counts in `fetch_count`.
- `fetch_count` increments when `out_valid && out_ready`.
- There are no branch delay slots. Any instruction after a jump that is fetched before the redirect is squashed.

## Timing
- Reset values:
  - `pc` = `RESET_PC`
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0
  - `fetch_count` = 0
  - state = `BOOT`
  - `imem_addr` = `RESET_PC` (combinational from `pc`)
- Reset is asynchronous in the middle of operation. All of the above take effect immediately and any held instruction is lost.
- Latency: an address presented in cycle N appears on `out_*` in cycle N+1. The first `out_valid` appears 2 cycles after reset release (the cycle after `BOOT`).
- Throughput: one instruction per cycle while `out_ready` is high.
- Redirect asserted in cycle N: the target is on `imem_addr` in cycle N+1 and its instruction is on `out_*` in cycle N+2. This gives exactly one bubble cycle.
- `out_*` are stable while `out_valid && !out_ready`.

## Configuration
- `INSTR_FETCH_JUMP_PREDECODE_EN`
  - Defined: fetch decodes `imem_instr[31:26] == 6'b000010` during capture and sets next_pc = `{pc_plus4[31:28], imem_instr[25:0], 2'b00}`. Jumps then cost zero bubbles. The `j` word is still emitted downstream.
  - A simultaneous external redirect still wins.
  - Undefined: next_pc is always `pc + 4`. A `j` is resolved only through `redirect_*`.

## Structure
- Shared `mips_pkg` holds:
  - `OPC_J = 6'b000010`
  - `PC_STEP = 32'd4`
  - the fetch state enum (`BOOT`, `RUN`, `HOLD`)
  - a typed IF/ID bundle (`instr`, `pc`, `pc_plus4`)
- One sub-module: `fetch_next_pc`, a combinational next-PC select (sequential, jump target, redirect, with priority). The state register, PC and output register stay in `instr_fetch`.

## Test plan
- ROM model with words 0x22000004, 0x22200006, 0x02119820, 0x08000000 at 0x0/0x4/0x8/0xC. Predecode on, `out_ready`=1 → `out_pc` = 0,4,8,C,0,4…; `out_instr` in order; first valid 2 cycles after reset release.
- Same program with predecode off, decode asserting redirect to 0 in the cycle after `out_pc`=0xC is accepted → word at 0x10 (0) emitted then squashed, 0x22000004 arrives exactly 2 cycles after redirect.
- `out_ready`=0 for 3 cycles while `out_pc`=4 → `out_*` held at 4/0x22200006, `imem_addr` held at 8, `fetch_count` frozen; resume gives 8 next.
- Redirect to 0x00000013 while holding → `imem_addr`=0x10 next cycle, held word dropped, `out_valid` low one cycle.
- Force `pc` near wrap (redirect 0xFFFFFFFC) → next `imem_addr`=0, `out_pc_plus4`=0.
- Assert `rst_n`=0 mid-stream for half a cycle → outputs zero immediately, `imem_addr`=`RESET_PC`, `fetch_count`=0, restart sequence identical to the first test.
